// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Operation/result valid-ready channels of the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [3:0]       alu_control;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_illegal;

  // Caller side: presents operations, consumes results.
  modport master (
    output in_valid, operand_1, operand_2, alu_control, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flag_zero, flag_carry, flag_illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, operand_1, operand_2, alu_control, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flag_zero, flag_carry, flag_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Handshaked ALU; single-cycle ops plus iterative shift-add MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_pipe_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0011;
  localparam logic [3:0] c_OP_SLL = 4'b0100;
  localparam logic [3:0] c_OP_SRL = 4'b0101;
  localparam logic [3:0] c_OP_XOR = 4'b0110;
  localparam logic [3:0] c_OP_OR  = 4'b0111;
  localparam logic [3:0] c_OP_MUL = 4'b1000;
  localparam logic [3:0] c_OP_LTU = 4'b1001;
  localparam logic [3:0] c_OP_GTU = 4'b1010;
  localparam logic [3:0] c_OP_EQ  = 4'b1011;
  localparam logic [3:0] c_OP_SRA = 4'b1100;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_zero;
  logic             r_carry;
  logic             r_illegal;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [TAG_W-1:0] r_mul_tag;
  logic [SH_W-1:0]  r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_illegal;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_mul_last;
  logic             w_is_mul;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_alu;
  logic             w_mul_step;
  logic             w_mul_done;

  // Single-cycle datapath; MUL opcode yields nothing here, the iterative unit owns it.
  always_comb begin
    w_sum         = {1'b0, bus.operand_1} + {1'b0, bus.operand_2};
    w_diff        = {1'b0, bus.operand_1} - {1'b0, bus.operand_2};
    w_shamt       = bus.operand_2[SH_W-1:0];
    w_alu_res     = '0;
    w_alu_carry   = 1'b0;
    w_alu_illegal = 1'b0;
    case (bus.alu_control)
      c_OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      c_OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
      end
      c_OP_AND: w_alu_res = bus.operand_1 & bus.operand_2;
      c_OP_SLL: w_alu_res = bus.operand_1 << w_shamt;
      c_OP_SRL: w_alu_res = bus.operand_1 >> w_shamt;
      c_OP_XOR: w_alu_res = bus.operand_1 ^ bus.operand_2;
      c_OP_OR:  w_alu_res = bus.operand_1 | bus.operand_2;
      c_OP_MUL: w_alu_res = '0;
      c_OP_LTU: w_alu_res = {{(WIDTH-1){1'b0}}, bus.operand_1 < bus.operand_2};
      c_OP_GTU: w_alu_res = {{(WIDTH-1){1'b0}}, bus.operand_1 > bus.operand_2};
      c_OP_EQ:  w_alu_res = {{(WIDTH-1){1'b0}}, bus.operand_1 == bus.operand_2};
      c_OP_SRA: w_alu_res = $unsigned($signed(bus.operand_1) >>> w_shamt);
      default:  w_alu_illegal = 1'b1;
    endcase
  end

  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == SH_W'(WIDTH - 1));
  assign w_is_mul   = (bus.alu_control == c_OP_MUL);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_load_alu = w_accept && !w_is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // The final MUL step is withheld while an older result is still unconsumed.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_mul_step   = 1'b0;
    w_mul_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = rst_n && (!r_out_valid || bus.out_ready);
        if (bus.in_valid && w_in_ready && w_is_mul) w_state_next = S_MUL;
      end
      S_MUL: begin
        if (!w_mul_last) begin
          w_mul_step = 1'b1;
        end else if (!r_out_valid || bus.out_ready) begin
          w_mul_step   = 1'b1;
          w_mul_done   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_illegal   <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_mul_tag   <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_load_alu) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_out_tag   <= bus.in_tag;
        r_zero      <= (w_alu_res == '0);
        r_carry     <= w_alu_carry;
        r_illegal   <= w_alu_illegal;
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_acc_step;
        r_out_tag   <= r_mul_tag;
        r_zero      <= (w_acc_step == '0);
        r_carry     <= 1'b0;
        r_illegal   <= 1'b0;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_is_mul) begin
        r_mcand   <= bus.operand_1;
        r_mplier  <= bus.operand_2;
        r_acc     <= '0;
        r_mul_tag <= bus.in_tag;
        r_cnt     <= '0;
      end else if (w_mul_step) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.result       = r_result;
  assign bus.out_tag      = r_out_tag;
  assign bus.flag_zero    = r_zero;
  assign bus.flag_carry   = r_carry;
  assign bus.flag_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic         ill;
    logic         carry;
    logic         zero;
    logic [W-1:0] res;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] wide;
    int          sh;
    e    = '0;
    wide = '0;
    sh   = int'(b % W);
    case (op)
      4'd1:  begin wide = 64'(a) + 64'(b); e.res = wide[W-1:0]; e.carry = wide[W]; end
      4'd2:  begin e.res = a - b; e.carry = (a < b); end
      4'd3:  e.res = a & b;
      4'd4:  e.res = a << sh;
      4'd5:  e.res = a >> sh;
      4'd6:  e.res = a ^ b;
      4'd7:  e.res = a | b;
      4'd8:  begin wide = 64'(a) * 64'(b); e.res = wide[W-1:0]; end
      4'd9:  e.res = (a < b) ? W'(1) : W'(0);
      4'd10: e.res = (a > b) ? W'(1) : W'(0);
      4'd11: e.res = (a == b) ? W'(1) : W'(0);
      4'd12: e.res = W'($signed(a) >>> sh);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid dropped.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = op; bus.operand_1 = a; bus.operand_2 = b; bus.in_tag = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1 acc = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (!acc) $display("FAIL send_accept: in_ready got 0 required 1 within 200 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.alu_control = 4'd1;
    bus.operand_1 = 32'd5; bus.operand_2 = 32'd6; bus.in_tag = 4'd1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.out_tag, bus.flag_zero, bus.flag_carry, bus.flag_illegal} !== '0)
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h tag=%h z=%b c=%b i=%b required all 0",
               bus.in_ready, bus.out_valid, bus.result, bus.out_tag, bus.flag_zero, bus.flag_carry, bus.flag_illegal);
    else n_pass++;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add();
    exp_t e;
    send(4'd1, 32'h1, 32'h12, 4'd3);
    n_chk++;
    if ({bus.out_valid, bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result} !== {1'b1, 4'd3, 3'b000, 32'h13})
      $display("FAIL add_small: got vld=%b tag=%h flags=%b%b%b res=%h required 1 3 000 00000013",
               bus.out_valid, bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result);
    else n_pass++;
    send(4'd1, 32'hFFFF_FFFF, 32'h1, 4'd4);
    n_chk++;
    if ({bus.flag_carry, bus.flag_zero, bus.result} !== {2'b11, 32'h0})
      $display("FAIL add_wrap: got c=%b z=%b res=%h required c=1 z=1 res=0", bus.flag_carry, bus.flag_zero, bus.result);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] a, b;
      a = $urandom; b = (k == 0) ? ~a : $urandom;
      e = model(4'd1, a, b);
      send(4'd1, a, b, 4'(k));
      n_chk++;
      if ({bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result} !== e)
        $display("FAIL add_rand: got %h required %h", {bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result}, e);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    exp_t e;
    send(4'd2, 32'h1, 32'h12, 4'd0);
    n_chk++;
    if ({bus.flag_carry, bus.result} !== {1'b1, 32'hFFFF_FFEF})
      $display("FAIL sub_borrow: got c=%b res=%h required c=1 res=ffffffef", bus.flag_carry, bus.result);
    else n_pass++;
    send(4'd12, 32'h8000_0000, 32'd4, 4'd0);
    n_chk++;
    if (bus.result !== 32'hF800_0000) $display("FAIL sra: got %h required f8000000", bus.result);
    else n_pass++;
    send(4'd4, 32'h1, 32'd33, 4'd0);
    n_chk++;
    if (bus.result !== 32'h2) $display("FAIL sll_masked: got %h required 00000002", bus.result);
    else n_pass++;
    for (int k = 0; k < 33; k++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'(k % 12 + 1);
      if (op == 4'd8) op = 4'd11;
      a = $urandom; b = (k % 5 == 0) ? a : $urandom;
      e = model(op, a, b);
      send(op, a, b, 4'(k));
      n_chk++;
      if ({bus.out_valid, bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result} !== {1'b1, 4'(k), e})
        $display("FAIL op%0d: a=%h b=%h got vld=%b tag=%h %h required 1 %h %h", op, a, b,
                 bus.out_valid, bus.out_tag, {bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result}, 4'(k), e);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int   n, busy;
    exp_t e;
    send(4'd8, 32'h1234, 32'h10, 4'd5);
    n = 0; busy = 0;
    while (!bus.out_valid && n < 100) begin
      if (!bus.in_ready) busy++;
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (busy !== 32 || n + 1 !== 33)
      $display("FAIL mul_latency: got busy=%0d valid_cycle=%0d required busy=32 valid_cycle=33", busy, n + 1);
    else n_pass++;
    n_chk++;
    if ({bus.out_valid, bus.out_tag, bus.flag_carry, bus.flag_zero, bus.result} !== {1'b1, 4'd5, 2'b00, 32'h12340})
      $display("FAIL mul_result: got vld=%b tag=%h c=%b z=%b res=%h required 1 5 0 0 00012340",
               bus.out_valid, bus.out_tag, bus.flag_carry, bus.flag_zero, bus.result);
    else n_pass++;
    @(negedge clk);
    begin
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      e = model(4'd8, a, b);
      send(4'd8, a, b, 4'd9);
      n = 0;
      while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
      n_chk++;
      if ({bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result} !== {4'd9, e})
        $display("FAIL mul_rand: a=%h b=%h got %h required %h", a, b,
                 {bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result}, {4'd9, e});
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t         m[3];
    logic [W-1:0] a[3], b[3];
    for (int k = 0; k < 3; k++) begin
      a[k] = $urandom; b[k] = $urandom; m[k] = model(4'd1, a[k], b[k]);
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = 4'd1; bus.operand_1 = a[0]; bus.operand_2 = b[0]; bus.in_tag = 4'd10;
    @(negedge clk);
    bus.operand_1 = a[1]; bus.operand_2 = b[1]; bus.in_tag = 4'd11;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if ({bus.out_valid, bus.in_ready, bus.out_tag, bus.result} !== {2'b10, 4'd10, m[0].res})
        $display("FAIL b2b_hold: got vld=%b rdy=%b tag=%h res=%h required 1 0 a %h",
                 bus.out_valid, bus.in_ready, bus.out_tag, bus.result, m[0].res);
      else n_pass++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.operand_1 = a[2]; bus.operand_2 = b[2]; bus.in_tag = 4'd12;
    n_chk++;
    if ({bus.out_valid, bus.out_tag, bus.result} !== {1'b1, 4'd11, m[1].res})
      $display("FAIL b2b_second: got vld=%b tag=%h res=%h required 1 b %h", bus.out_valid, bus.out_tag, bus.result, m[1].res);
    else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.out_valid, bus.out_tag, bus.result} !== {1'b1, 4'd12, m[2].res})
      $display("FAIL b2b_third: got vld=%b tag=%h res=%h required 1 c %h", bus.out_valid, bus.out_tag, bus.result, m[2].res);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid got %b required 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    send(4'hF, $urandom, $urandom, 4'd7);
    n_chk++;
    if ({bus.out_valid, bus.flag_illegal, bus.flag_zero, bus.flag_carry, bus.result} !== {4'b1110, 32'h0})
      $display("FAIL illegal: got vld=%b i=%b z=%b c=%b res=%h required 1 1 1 0 0",
               bus.out_valid, bus.flag_illegal, bus.flag_zero, bus.flag_carry, bus.result);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mul_reset();
    int seen;
    send(4'd8, 32'h77, 32'h33, 4'd2);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL mul_abort: out_valid cycles got %0d required 0", seen);
    else n_pass++;
    send(4'd6, 32'hF0F0_0000, 32'h0F0F_1234, 4'd6);
    n_chk++;
    if ({bus.out_valid, bus.out_tag, bus.result} !== {1'b1, 4'd6, 32'hFFFF_1234})
      $display("FAIL after_abort: got vld=%b tag=%h res=%h required 1 6 ffff1234", bus.out_valid, bus.out_tag, bus.result);
    else n_pass++;
    @(negedge clk);
  endtask

  // Random traffic with random back-pressure, scoreboarded in acceptance order.
  task automatic test_random();
    exp_t                     q_e[$];
    logic [TW-1:0]            q_t[$];
    logic                     held;
    logic [W+TW+2:0]          held_val;
    logic [W+TW+2:0]          obs;
    held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd1;
      bus.in_valid    = (cyc < 400) && ($urandom_range(0, 3) != 0);
      bus.alu_control = op;
      bus.operand_1   = $urandom;
      bus.operand_2   = ($urandom_range(0, 4) == 0) ? bus.operand_1 : $urandom;
      bus.in_tag      = 4'($urandom);
      bus.out_ready   = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      #1;
      obs = {bus.out_tag, bus.flag_illegal, bus.flag_carry, bus.flag_zero, bus.result};
      if (held) begin
        n_chk++;
        if (bus.out_valid !== 1'b1 || obs !== held_val)
          $display("FAIL rand_hold: got vld=%b %h required 1 %h", bus.out_valid, obs, held_val);
        else n_pass++;
      end
      held = bus.out_valid && !bus.out_ready;
      held_val = obs;
      if (bus.out_valid && bus.out_ready) begin
        n_chk++;
        if (q_e.size() == 0) $display("FAIL rand_extra: got output %h required none pending", obs);
        else if (obs !== {q_t[0], q_e[0]}) $display("FAIL rand_result: got %h required %h", obs, {q_t[0], q_e[0]});
        else n_pass++;
        if (q_e.size() != 0) begin void'(q_e.pop_front()); void'(q_t.pop_front()); end
      end
      if (bus.in_valid && bus.in_ready) begin
        q_e.push_back(model(bus.alu_control, bus.operand_1, bus.operand_2));
        q_t.push_back(bus.in_tag);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (q_e.size() !== 0) $display("FAIL rand_drain: pending got %0d required 0", q_e.size());
    else n_pass++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.alu_control = 4'd0; bus.operand_1 = '0; bus.operand_2 = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_mul_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
